// File: rtl/banked_pingpong_ram_if.sv
// Bus bundle for banked_pingpong_ram: producer/consumer A/B ports plus the ownership handshake.
// The master modport belongs to the producer/consumer side, and the slave modport belongs to the RAM.
interface banked_pingpong_ram_if #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 20,
  parameter int NUM_BANKS  = 2
);
  localparam int BANK_W = $clog2(NUM_BANKS);

  logic                  p_en_a, p_we_a, p_en_b, p_we_b;
  logic [ADDR_WIDTH-1:0] p_addr_a, p_addr_b;
  logic [DATA_WIDTH-1:0] p_din_a, p_din_b, p_dout_a, p_dout_b;
  logic                  c_en_a, c_we_a, c_en_b, c_we_b;
  logic [ADDR_WIDTH-1:0] c_addr_a, c_addr_b;
  logic [DATA_WIDTH-1:0] c_din_a, c_din_b, c_dout_a, c_dout_b;

  // Ownership handshake. p_ready means the producer owns bank p_bank.
  // A p_done pulse that arrives while p_ready is high hands that bank to the
  // consumer. c_valid means the consumer owns the full bank c_bank.
  // A c_done pulse that arrives while c_valid is high hands that bank back to
  // the producer. A done pulse that arrives without ready/valid is ignored,
  // and it sets a sticky error flag.
  logic                  p_ready, p_done, c_valid, c_done;
  logic [BANK_W-1:0]     p_bank, c_bank;
  logic [BANK_W:0]       full_cnt;
  logic                  err_ovf, err_udf;

  modport master (
    output p_en_a, p_we_a, p_addr_a, p_din_a, p_en_b, p_we_b, p_addr_b, p_din_b,
    output c_en_a, c_we_a, c_addr_a, c_din_a, c_en_b, c_we_b, c_addr_b, c_din_b,
    output p_done, c_done,
    input  p_dout_a, p_dout_b, c_dout_a, c_dout_b,
    input  p_ready, c_valid, p_bank, c_bank, full_cnt, err_ovf, err_udf
  );

  modport slave (
    input  p_en_a, p_we_a, p_addr_a, p_din_a, p_en_b, p_we_b, p_addr_b, p_din_b,
    input  c_en_a, c_we_a, c_addr_a, c_din_a, c_en_b, c_we_b, c_addr_b, c_din_b,
    input  p_done, c_done,
    output p_dout_a, p_dout_b, c_dout_a, c_dout_b,
    output p_ready, c_valid, p_bank, c_bank, full_cnt, err_ovf, err_udf
  );
endinterface

// File: rtl/banked_pingpong_ram.sv
// N-bank ping-pong RAM. The producer fills one bank while the consumer drains another.
// Ownership rotates through done handshakes.
module banked_pingpong_ram #(
  parameter int ADDR_WIDTH = 7,
  parameter int MEM_SIZE   = 128,
  parameter int DATA_WIDTH = 20,
  parameter int NUM_BANKS  = 2
) (
  input logic                  clk,
  input logic                  rst,
  banked_pingpong_ram_if.slave bus
);
  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam logic [BANK_W-1:0]   LAST_BANK = BANK_W'(NUM_BANKS - 1);
  localparam logic [BANK_W:0]     FULL_LVL  = (BANK_W + 1)'(NUM_BANKS);
  localparam logic [ADDR_WIDTH:0] ADDR_LIM  = (ADDR_WIDTH + 1)'(MEM_SIZE);

  logic [BANK_W-1:0] wr_ptr, rd_ptr, wr_ptr_d, rd_ptr_d;
  logic [BANK_W:0]   full_cnt, full_cnt_d;
  logic              err_ovf, err_udf, err_ovf_d, err_udf_d;
  logic              p_ready, c_valid, p_acc, c_acc;
  logic              pa_en, pb_en, ca_en, cb_en;
  logic [DATA_WIDTH-1:0] p_dout_a, p_dout_b, c_dout_a, c_dout_b;
  logic [DATA_WIDTH-1:0] mem [NUM_BANKS][MEM_SIZE];

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return {1'b0, a} < ADDR_LIM;
  endfunction

  assign p_ready = (full_cnt != FULL_LVL);
  assign c_valid = (full_cnt != '0);
  assign p_acc   = bus.p_done & p_ready;
  assign c_acc   = bus.c_done & c_valid;

  // Each side only reaches memory while it owns a bank, so the two sides never alias.
  assign pa_en = bus.p_en_a & p_ready;
  assign pb_en = bus.p_en_b & p_ready;
  assign ca_en = bus.c_en_a & c_valid;
  assign cb_en = bus.c_en_b & c_valid;

  always_comb begin
    wr_ptr_d   = wr_ptr;
    rd_ptr_d   = rd_ptr;
    full_cnt_d = full_cnt;
    err_ovf_d  = err_ovf | (bus.p_done & ~p_ready);
    err_udf_d  = err_udf | (bus.c_done & ~c_valid);
    if (p_acc) wr_ptr_d = (wr_ptr == LAST_BANK) ? '0 : wr_ptr + BANK_W'(1);
    if (c_acc) rd_ptr_d = (rd_ptr == LAST_BANK) ? '0 : rd_ptr + BANK_W'(1);
    case ({p_acc, c_acc})
      2'b10:   full_cnt_d = full_cnt + (BANK_W + 1)'(1);
      2'b01:   full_cnt_d = full_cnt - (BANK_W + 1)'(1);
      default: full_cnt_d = full_cnt;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      full_cnt <= '0;
      err_ovf  <= 1'b0;
      err_udf  <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr_d;
      rd_ptr   <= rd_ptr_d;
      full_cnt <= full_cnt_d;
      err_ovf  <= err_ovf_d;
      err_udf  <= err_udf_d;
    end
  end

  // The storage is not reset. Port B is written last, so when both ports write the same word, port B wins.
  always_ff @(posedge clk) begin
    if (pa_en && bus.p_we_a && in_range(bus.p_addr_a)) mem[wr_ptr][bus.p_addr_a] <= bus.p_din_a;
    if (pb_en && bus.p_we_b && in_range(bus.p_addr_b)) mem[wr_ptr][bus.p_addr_b] <= bus.p_din_b;
    if (ca_en && bus.c_we_a && in_range(bus.c_addr_a)) mem[rd_ptr][bus.c_addr_a] <= bus.c_din_a;
    if (cb_en && bus.c_we_b && in_range(bus.c_addr_b)) mem[rd_ptr][bus.c_addr_b] <= bus.c_din_b;
  end

  // Reads sample pre-edge memory (read-first) and use the pre-edge pointer, so a read in a done cycle hits the old bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_dout_a <= '0;
      p_dout_b <= '0;
      c_dout_a <= '0;
      c_dout_b <= '0;
    end else begin
      if (pa_en) p_dout_a <= in_range(bus.p_addr_a) ? mem[wr_ptr][bus.p_addr_a] : '0;
      if (pb_en) p_dout_b <= in_range(bus.p_addr_b) ? mem[wr_ptr][bus.p_addr_b] : '0;
      if (ca_en) c_dout_a <= in_range(bus.c_addr_a) ? mem[rd_ptr][bus.c_addr_a] : '0;
      if (cb_en) c_dout_b <= in_range(bus.c_addr_b) ? mem[rd_ptr][bus.c_addr_b] : '0;
    end
  end

  assign bus.p_dout_a = p_dout_a;
  assign bus.p_dout_b = p_dout_b;
  assign bus.c_dout_a = c_dout_a;
  assign bus.c_dout_b = c_dout_b;
  assign bus.p_ready  = p_ready;
  assign bus.c_valid  = c_valid;
  assign bus.p_bank   = wr_ptr;
  assign bus.c_bank   = rd_ptr;
  assign bus.full_cnt = full_cnt;
  assign bus.err_ovf  = err_ovf;
  assign bus.err_udf  = err_udf;
endmodule

// File: tb/tb_banked_pingpong_ram.sv
// Directed bench for banked_pingpong_ram: a two-bank instance for the handshake and RAM corner cases,
// plus a three-bank instance for pointer wrap and reset in the middle of a burst.
module tb_banked_pingpong_ram;
  logic clk = 1'b0;
  logic rst2 = 1'b1;
  logic rst3 = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  banked_pingpong_ram_if #(.ADDR_WIDTH(7), .DATA_WIDTH(20), .NUM_BANKS(2)) b2 ();
  banked_pingpong_ram_if #(.ADDR_WIDTH(7), .DATA_WIDTH(20), .NUM_BANKS(3)) b3 ();

  banked_pingpong_ram #(.ADDR_WIDTH(7), .MEM_SIZE(128), .DATA_WIDTH(20), .NUM_BANKS(2)) u_dut2 (
    .clk(clk), .rst(rst2), .bus(b2.slave)
  );
  banked_pingpong_ram #(.ADDR_WIDTH(7), .MEM_SIZE(128), .DATA_WIDTH(20), .NUM_BANKS(3)) u_dut3 (
    .clk(clk), .rst(rst3), .bus(b3.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle2();
    b2.p_en_a = 0; b2.p_we_a = 0; b2.p_addr_a = '0; b2.p_din_a = '0;
    b2.p_en_b = 0; b2.p_we_b = 0; b2.p_addr_b = '0; b2.p_din_b = '0;
    b2.c_en_a = 0; b2.c_we_a = 0; b2.c_addr_a = '0; b2.c_din_a = '0;
    b2.c_en_b = 0; b2.c_we_b = 0; b2.c_addr_b = '0; b2.c_din_b = '0;
    b2.p_done = 0; b2.c_done = 0;
  endtask

  task automatic idle3();
    b3.p_en_a = 0; b3.p_we_a = 0; b3.p_addr_a = '0; b3.p_din_a = '0;
    b3.p_en_b = 0; b3.p_we_b = 0; b3.p_addr_b = '0; b3.p_din_b = '0;
    b3.c_en_a = 0; b3.c_we_a = 0; b3.c_addr_a = '0; b3.c_din_a = '0;
    b3.c_en_b = 0; b3.c_we_b = 0; b3.c_addr_b = '0; b3.c_din_b = '0;
    b3.p_done = 0; b3.c_done = 0;
  endtask

  initial begin
    idle2();
    idle3();
    tick(); tick();
    rst2 = 0;
    rst3 = 0;
    tick();

    // Reset state
    check("rst_p_ready", 32'(b2.p_ready), 1);
    check("rst_c_valid", 32'(b2.c_valid), 0);
    check("rst_p_bank", 32'(b2.p_bank), 0);
    check("rst_c_bank", 32'(b2.c_bank), 0);
    check("rst_full_cnt", 32'(b2.full_cnt), 0);
    check("rst_err_ovf", 32'(b2.err_ovf), 0);
    check("rst_err_udf", 32'(b2.err_udf), 0);
    check("rst_c_dout_a", 32'(b2.c_dout_a), 0);

    // Empty: c_done plus a consumer read while nothing is full
    b2.c_done = 1; b2.c_en_a = 1; b2.c_addr_a = 7'd3;
    tick(); idle2();
    check("udf_flag", 32'(b2.err_udf), 1);
    check("udf_c_bank", 32'(b2.c_bank), 0);
    check("udf_full_cnt", 32'(b2.full_cnt), 0);
    check("udf_c_dout_hold", 32'(b2.c_dout_a), 0);

    // Producer fills bank 0, then hands it over
    b2.p_en_a = 1; b2.p_we_a = 1; b2.p_addr_a = 7'd3; b2.p_din_a = 20'h00005;
    b2.p_en_b = 1; b2.p_we_b = 1; b2.p_addr_b = 7'd4; b2.p_din_b = 20'hFFFFF;
    tick(); idle2();
    b2.p_done = 1;
    tick(); idle2();
    check("h1_full_cnt", 32'(b2.full_cnt), 1);
    check("h1_c_valid", 32'(b2.c_valid), 1);
    check("h1_c_bank", 32'(b2.c_bank), 0);
    check("h1_p_bank", 32'(b2.p_bank), 1);
    b2.c_en_a = 1; b2.c_addr_a = 7'd3;
    b2.c_en_b = 1; b2.c_addr_b = 7'd4;
    tick(); idle2();
    check("h1_c_dout_a", 32'(b2.c_dout_a), 32'h00005);
    check("h1_c_dout_b", 32'(b2.c_dout_b), 32'hFFFFF);

    // Overlap: producer writes bank 1 while the consumer reads bank 0
    b2.p_en_a = 1; b2.p_we_a = 1; b2.p_addr_a = 7'd3; b2.p_din_a = 20'hAAAAA;
    b2.p_en_b = 1; b2.p_we_b = 1; b2.p_addr_b = 7'd4; b2.p_din_b = 20'h55555;
    b2.c_en_a = 1; b2.c_addr_a = 7'd4;
    b2.c_en_b = 1; b2.c_addr_b = 7'd3;
    tick(); idle2();
    check("ov_c_dout_a", 32'(b2.c_dout_a), 32'hFFFFF);
    check("ov_c_dout_b", 32'(b2.c_dout_b), 32'h00005);
    b2.p_en_a = 1; b2.p_addr_a = 7'd3;
    tick(); idle2();
    check("ov_p_dout_a", 32'(b2.p_dout_a), 32'hAAAAA);

    // Simultaneous done. Accesses in this cycle still target the old banks.
    b2.p_done = 1; b2.c_done = 1;
    b2.p_en_b = 1; b2.p_we_b = 1; b2.p_addr_b = 7'd5; b2.p_din_b = 20'h77777;
    b2.c_en_a = 1; b2.c_addr_a = 7'd3;
    tick(); idle2();
    check("sw_full_cnt", 32'(b2.full_cnt), 1);
    check("sw_p_bank", 32'(b2.p_bank), 0);
    check("sw_c_bank", 32'(b2.c_bank), 1);
    check("sw_old_bank_read", 32'(b2.c_dout_a), 32'h00005);
    b2.c_en_a = 1; b2.c_addr_a = 7'd3;
    b2.c_en_b = 1; b2.c_addr_b = 7'd5;
    tick(); idle2();
    check("sw_c_bank1_a", 32'(b2.c_dout_a), 32'hAAAAA);
    check("sw_c_bank1_b", 32'(b2.c_dout_b), 32'h77777);

    // Both ports write the same address, and port B wins
    b2.p_en_a = 1; b2.p_we_a = 1; b2.p_addr_a = 7'd10; b2.p_din_a = 20'h00001;
    b2.p_en_b = 1; b2.p_we_b = 1; b2.p_addr_b = 7'd10; b2.p_din_b = 20'h00002;
    tick(); idle2();
    b2.p_en_a = 1; b2.p_addr_a = 7'd10;
    tick(); idle2();
    check("ab_collide", 32'(b2.p_dout_a), 32'h00002);

    // Read-first on the same port, and old data on a cross-port read
    b2.p_en_a = 1; b2.p_we_a = 1; b2.p_addr_a = 7'd3; b2.p_din_a = 20'h33333;
    b2.p_en_b = 1; b2.p_addr_b = 7'd3;
    tick(); idle2();
    check("rdw_same_port", 32'(b2.p_dout_a), 32'h00005);
    check("rdw_cross_port", 32'(b2.p_dout_b), 32'h00005);
    b2.p_en_a = 1; b2.p_addr_a = 7'd3;
    tick(); idle2();
    check("rdw_written", 32'(b2.p_dout_a), 32'h33333);

    // Full: the producer loses ownership, and its accesses are gated
    b2.p_done = 1;
    tick(); idle2();
    check("full_cnt2", 32'(b2.full_cnt), 2);
    check("full_p_ready", 32'(b2.p_ready), 0);
    check("full_c_valid", 32'(b2.c_valid), 1);
    b2.p_en_a = 1; b2.p_we_a = 1; b2.p_addr_a = 7'd3; b2.p_din_a = 20'h12345;
    b2.p_en_b = 1; b2.p_addr_b = 7'd3;
    tick(); idle2();
    check("full_p_dout_a_hold", 32'(b2.p_dout_a), 32'h33333);
    check("full_p_dout_b_hold", 32'(b2.p_dout_b), 32'h00005);
    b2.c_en_a = 1; b2.c_addr_a = 7'd3;
    tick(); idle2();
    check("full_write_dropped", 32'(b2.c_dout_a), 32'hAAAAA);
    b2.p_done = 1;
    tick(); idle2();
    check("ovf_flag", 32'(b2.err_ovf), 1);
    check("ovf_full_cnt", 32'(b2.full_cnt), 2);
    check("ovf_p_bank", 32'(b2.p_bank), 1);

    // Drain both banks
    b2.c_done = 1;
    tick(); idle2();
    check("dr1_full_cnt", 32'(b2.full_cnt), 1);
    check("dr1_c_bank", 32'(b2.c_bank), 0);
    check("dr1_p_ready", 32'(b2.p_ready), 1);
    b2.c_en_a = 1; b2.c_addr_a = 7'd10;
    b2.c_en_b = 1; b2.c_addr_b = 7'd3;
    tick(); idle2();
    check("dr1_c_dout_a", 32'(b2.c_dout_a), 32'h00002);
    check("dr1_c_dout_b", 32'(b2.c_dout_b), 32'h33333);
    b2.c_done = 1;
    tick(); idle2();
    check("dr2_full_cnt", 32'(b2.full_cnt), 0);
    check("dr2_c_valid", 32'(b2.c_valid), 0);
    check("dr2_c_bank", 32'(b2.c_bank), 1);
    check("dr2_udf_sticky", 32'(b2.err_udf), 1);

    // Three banks: seven produce/consume rounds wrap the pointers
    for (int r = 0; r < 7; r++) begin
      b3.p_en_a = 1; b3.p_we_a = 1; b3.p_addr_a = 7'd0; b3.p_din_a = 20'(32'h100 + r);
      b3.p_done = 1;
      tick(); idle3();
      check("r3_p_bank", 32'(b3.p_bank), 32'((r + 1) % 3));
      check("r3_full_cnt_p", 32'(b3.full_cnt), 1);
      b3.c_en_a = 1; b3.c_addr_a = 7'd0; b3.c_done = 1;
      tick(); idle3();
      check("r3_c_dout", 32'(b3.c_dout_a), 32'h100 + r);
      check("r3_c_bank", 32'(b3.c_bank), 32'((r + 1) % 3));
    end
    check("r3_full_cnt_end", 32'(b3.full_cnt), 0);

    // Fill all three banks, then overflow once
    for (int i = 0; i < 3; i++) begin
      b3.p_en_a = 1; b3.p_we_a = 1; b3.p_addr_a = 7'd1; b3.p_din_a = 20'(32'h200 + i);
      b3.p_done = 1;
      tick(); idle3();
    end
    check("f3_full_cnt", 32'(b3.full_cnt), 3);
    check("f3_p_ready", 32'(b3.p_ready), 0);
    b3.p_done = 1;
    tick(); idle3();
    check("f3_full_cnt_cap", 32'(b3.full_cnt), 3);
    check("f3_err_ovf", 32'(b3.err_ovf), 1);

    // Reset in the middle of a consumer burst
    b3.c_en_a = 1; b3.c_addr_a = 7'd1;
    tick();
    check("mr_pre_c_dout", 32'(b3.c_dout_a), 32'h200);
    #2 rst3 = 1;
    #1;
    check("mr_full_cnt", 32'(b3.full_cnt), 0);
    check("mr_p_bank", 32'(b3.p_bank), 0);
    check("mr_c_bank", 32'(b3.c_bank), 0);
    check("mr_p_ready", 32'(b3.p_ready), 1);
    check("mr_c_valid", 32'(b3.c_valid), 0);
    check("mr_err_ovf", 32'(b3.err_ovf), 0);
    check("mr_c_dout", 32'(b3.c_dout_a), 0);
    tick(); idle3();
    rst3 = 0;
    tick();

    // RAM contents survive the reset
    b3.p_done = 1;
    tick(); idle3();
    b3.c_en_a = 1; b3.c_addr_a = 7'd0;
    tick(); idle3();
    check("mr_ram_persist", 32'(b3.c_dout_a), 32'h106);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/banked_pingpong_ram.md
Name: banked_pingpong_ram

Overview:
- N-bank double/multi-buffered RAM for the Jacobi datapath.
- A producer interface and a consumer interface each have two ports, A and B.
- Bank ownership is handed from producer to consumer, then back, through done/ready handshakes. Software never drives a manual select.
- Lets the rotation engine write sweep k+1 while the readout/next stage reads sweep k.

Parameters:
ADDR_WIDTH, 7, address bits per bank
MEM_SIZE, 128, words per bank (<= 2**ADDR_WIDTH)
DATA_WIDTH, 20, word width
NUM_BANKS, 2, number of banks (>= 2)
BANK_W, $clog2(NUM_BANKS), width of bank index outputs (localparam)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
p_en_a, p_we_a  in  1  producer port A enable / write enable
p_addr_a  in  ADDR_WIDTH  producer port A address
p_din_a  in  DATA_WIDTH  producer port A write data
p_dout_a  out  DATA_WIDTH  producer port A read data
p_en_b, p_we_b, p_addr_b, p_din_b, p_dout_b  as port A  producer port B
c_en_a, c_we_a, c_addr_a, c_din_a, c_dout_a  as above  consumer port A
c_en_b, c_we_b, c_addr_b, c_din_b, c_dout_b  as above  consumer port B
p_ready  out  1  producer owns a bank
p_done  in  1  pulse: producer releases current bank as full
c_valid  out  1  consumer owns a full bank
c_done  in  1  pulse: consumer releases current bank as empty
p_bank, c_bank  out  BANK_W  bank currently owned by producer / consumer
full_cnt  out  BANK_W+1  number of full banks (0..NUM_BANKS)
err_ovf, err_udf  out  1  sticky: p_done while !p_ready / c_done while !c_valid

Behaviour:
- Reset (async, rst=1):
  - wr_ptr=0, rd_ptr=0, full_cnt=0.
  - err_ovf=err_udf=0.
  - All dout=0.
  - Memory contents are not reset.
- Ownership flags:
  - p_ready = (full_cnt != NUM_BANKS).
  - c_valid = (full_cnt != 0).
  - p_bank = wr_ptr, c_bank = rd_ptr.
  - Producer and consumer never own the same bank at the same time.
- Handshake, evaluated on the rising edge using pre-edge state:
  - p_done & p_ready: wr_ptr <= (wr_ptr+1) mod NUM_BANKS, full_cnt+1.
  - c_done & c_valid: rd_ptr <= (rd_ptr+1) mod NUM_BANKS, full_cnt-1.
  - Both accepted in the same cycle: both pointers advance, full_cnt unchanged.
  - p_done & !p_ready: ignored, err_ovf <= 1.
  - c_done & !c_valid: ignored, err_udf <= 1.
  - Error flags are cleared only by rst.
- Access gating:
  - Each interface port drives its owned bank's matching port only while that interface owns a bank. p_* is gated by p_ready; c_* is gated by c_valid.
  - When not owned, en is forced 0: no write, and dout holds its last value.
  - An access in the same cycle as an accepted done targets the old bank.
- Bank RAM:
  - True dual-port, synchronous, one write-first-free model.
  - Read latency 1: dout is valid on the cycle after the en edge.
  - Same-port read-during-write returns old data (read-first).
  - Cross-port read of an address being written returns old data.
  - Both ports writing the same address: port B data wins.
  - dout holds when en=0.
- Read mux: the dout select uses the bank index registered with the access, not the current pointer. Read data issued in the done cycle therefore comes from the old bank.
- Address >= MEM_SIZE: write is dropped, read data is undefined; no flag.
- Reset mid-operation:
  - Pointers and counters clear immediately.
  - In-flight read data is discarded (dout=0).
  - RAM contents persist.

Test Plan:
- (NUM_BANKS=2) After reset: p_ready=1, c_valid=0, p_bank=0, full_cnt=0. Producer writes 0x00005 to addr 3 (A) and 0xFFFFF to addr 4 (B), then pulses p_done -> full_cnt=1, c_valid=1, c_bank=0, p_bank=1. Consumer reads addr 3/4 -> 0x00005/0xFFFFF one cycle later.
- Ping-pong overlap: producer fills bank 1 while the consumer reads bank 0. p_done and c_done in the same cycle -> full_cnt stays 1, p_bank=0, c_bank=1. Each side sees its own data with no cross-bank corruption.
- Full: two p_done without c_done -> full_cnt=2, p_ready=0. A producer write to addr 0 of 0x12345 is dropped, and a readback of bank 0 shows the old value. A third p_done sets err_ovf=1 and full_cnt stays 2.
- Empty: c_done at reset -> err_udf=1, rd_ptr=0. Consumer reads while c_valid=0 leave c_dout_a unchanged.
- Read issued in the same cycle as c_done -> data returned from the old bank. Same-address A/B write of 0x00001/0x00002 -> reads 0x00002.
- NUM_BANKS=3: run 7 produce/consume rounds -> pointers wrap 0,1,2,0 and full_cnt never exceeds 3. Assert rst mid-burst -> all outputs return to reset values within the same cycle.
